// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-lane round-robin front end for one shared pipelined multiplier
// Optional MUL_HIGH_EN adds i_req_op (mul/mulh/mulhsu/mulhu) selecting the low or high product half.
module mul_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [2*WIDTH-1:0]   i_req_a,
  input  logic [2*WIDTH-1:0]   i_req_b,
  input  logic [2*TAG_W-1:0]   i_req_tag,
`ifdef MUL_HIGH_EN
  input  logic [3:0]           i_req_op,
`endif
  input  logic                 i_resp_ready,
  output logic                 o_resp_valid,
  output logic                 o_resp_lane,
  output logic [TAG_W-1:0]     o_resp_tag,
  output logic [WIDTH-1:0]     o_resp_data,
  output logic                 o_busy
);

  logic [MUL_LAT-1:0] r_valid;
  logic [MUL_LAT-1:0] r_lane;
  logic [TAG_W-1:0]   r_tag  [MUL_LAT];
  logic [WIDTH-1:0]   r_data [MUL_LAT];
  logic               r_rr_ptr;

  logic               w_stall;
  logic               w_accept;
  logic [1:0]         w_grant;
  logic               w_xfer;
  logic               w_lane;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [TAG_W-1:0]   w_tag;
  logic [WIDTH-1:0]   w_result;

  assign w_stall  = o_resp_valid & ~i_resp_ready;
  // Reset gating keeps the combinational ready low while the async reset is held.
  assign w_accept = ~w_stall & ~i_flush & ~i_reset;

  always_comb begin
    w_grant = i_req_valid;
    if (i_req_valid == 2'b11)
      w_grant = r_rr_ptr ? 2'b10 : 2'b01;
  end

  assign o_req_ready = w_accept ? w_grant : 2'b00;
  assign w_xfer      = |o_req_ready;
  assign w_lane      = w_grant[1];

  assign w_a   = w_lane ? i_req_a[WIDTH +: WIDTH]   : i_req_a[0 +: WIDTH];
  assign w_b   = w_lane ? i_req_b[WIDTH +: WIDTH]   : i_req_b[0 +: WIDTH];
  assign w_tag = w_lane ? i_req_tag[TAG_W +: TAG_W] : i_req_tag[0 +: TAG_W];

`ifdef MUL_HIGH_EN
  logic [1:0]         w_op;
  logic               w_a_sgn;
  logic               w_b_sgn;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_full;

  assign w_op    = w_lane ? i_req_op[3:2] : i_req_op[1:0];
  assign w_a_sgn = (w_op == 2'b01) | (w_op == 2'b10);
  assign w_b_sgn = (w_op == 2'b01);
  // Sign/zero-extending both operands to 2*WIDTH makes one unsigned multiply serve all three high ops.
  assign w_ext_a = {{WIDTH{w_a_sgn & w_a[WIDTH-1]}}, w_a};
  assign w_ext_b = {{WIDTH{w_b_sgn & w_b[WIDTH-1]}}, w_b};
  assign w_full  = w_ext_a * w_ext_b;
  assign w_result = (w_op == 2'b00) ? w_full[WIDTH-1:0] : w_full[2*WIDTH-1:WIDTH];
`else
  assign w_result = w_a * w_b;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid  <= '0;
      r_lane   <= '0;
      r_rr_ptr <= 1'b0;
      for (int k = 0; k < MUL_LAT; k++) begin
        r_tag[k]  <= '0;
        r_data[k] <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (!w_stall) begin
      r_valid[0] <= w_xfer;
      r_lane[0]  <= w_lane;
      r_tag[0]   <= w_tag;
      r_data[0]  <= w_result;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_lane[k]  <= r_lane[k-1];
        r_tag[k]   <= r_tag[k-1];
        r_data[k]  <= r_data[k-1];
      end
      if (w_xfer)
        r_rr_ptr <= ~w_lane;
    end
  end

  assign o_resp_valid = r_valid[MUL_LAT-1];
  assign o_resp_lane  = r_lane[MUL_LAT-1];
  assign o_resp_tag   = r_tag[MUL_LAT-1];
  assign o_resp_data  = r_data[MUL_LAT-1];
  assign o_busy       = |r_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed-vector bench for mul_share_arbiter (MUL_LAT=2)
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [9:0]  req_tag = '0;
`ifdef MUL_HIGH_EN
  logic [3:0]  req_op = '0;
`endif
  logic        resp_ready = 1'b1;
  logic        resp_valid;
  logic        resp_lane;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mul_share_arbiter #(.WIDTH(32), .TAG_W(5), .MUL_LAT(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_tag(req_tag),
`ifdef MUL_HIGH_EN
    .i_req_op(req_op),
`endif
    .i_resp_ready(resp_ready), .o_resp_valid(resp_valid), .o_resp_lane(resp_lane),
    .o_resp_tag(resp_tag), .o_resp_data(resp_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [1:0] op);
    req_a[lane*32 +: 32] = a;
    req_b[lane*32 +: 32] = b;
    req_tag[lane*5 +: 5] = tag;
`ifdef MUL_HIGH_EN
    req_op[lane*2 +: 2] = op;
`else
    if (op != 2'b00) $display("note: op ignored without MUL_HIGH_EN");
`endif
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #2;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (resp_lane !== 1'b0 || resp_tag !== 5'd0 || resp_data !== 32'd0)
      begin n_err++; $display("FAIL reset_resp got lane=%b tag=%0d data=%h exp 0/0/0", resp_lane, resp_tag, resp_data); end
    req_valid = 2'b00;
    #10 reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    set_lane(0, 32'd7, 32'd6, 5'd3, 2'b00);
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL single_stage1 got valid=%b busy=%b exp 0/1", resp_valid, busy); end
    step();
    n_vec++; if (resp_valid !== 1'b1 || resp_lane !== 1'b0 || resp_tag !== 5'd3 || resp_data !== 32'd42)
      begin n_err++; $display("FAIL single_resp got v=%b lane=%b tag=%0d data=%0d exp 1/0/3/42", resp_valid, resp_lane, resp_tag, resp_data); end
    step();
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL single_drain got valid=%b busy=%b exp 0/0", resp_valid, busy); end
  endtask

  task automatic test_contention();
    logic       exp_lane;
    logic [4:0] exp_tag;
    logic [31:0] exp_data;
    do_reset();
    resp_ready = 1'b1;
    set_lane(0, 32'd3, 32'd5, 5'd1, 2'b00);
    set_lane(1, 32'd4, 32'd9, 5'd2, 2'b00);
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      if (c < 4) begin
        n_vec++; if (req_ready !== ((c % 2 == 1) ? 2'b10 : 2'b01))
          begin n_err++; $display("FAIL contend_grant c=%0d got %b exp %b", c, req_ready, (c % 2 == 1) ? 2'b10 : 2'b01); end
      end
      if (c >= 2 && c <= 5) begin
        exp_lane = ((c - 2) % 2 == 1);
        exp_tag  = exp_lane ? 5'd2 : 5'd1;
        exp_data = exp_lane ? 32'd36 : 32'd15;
        n_vec++; if (resp_valid !== 1'b1 || resp_lane !== exp_lane || resp_tag !== exp_tag || resp_data !== exp_data)
          begin n_err++; $display("FAIL contend_resp c=%0d got v=%b lane=%b tag=%0d data=%0d exp 1/%b/%0d/%0d", c, resp_valid, resp_lane, resp_tag, resp_data, exp_lane, exp_tag, exp_data); end
      end
      if (c == 6) begin
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL contend_end got %b exp 0", resp_valid); end
      end
      step();
    end
  endtask

  task automatic test_back_pressure();
    resp_ready = 1'b0;
    set_lane(0, 32'd2, 32'd3, 5'd5, 2'b00);
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_ready0 got %b exp 01", req_ready); end
    step();
    set_lane(1, 32'd5, 32'd5, 5'd6, 2'b00);
    req_valid = 2'b10;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_ready1 got %b exp 10", req_ready); end
    step();
    set_lane(0, 32'd9, 32'd9, 5'd9, 2'b00);
    req_valid = 2'b01;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_stall_ready j=%0d got %b exp 00", j, req_ready); end
      n_vec++; if (resp_valid !== 1'b1 || resp_lane !== 1'b0 || resp_tag !== 5'd5 || resp_data !== 32'd6 || busy !== 1'b1)
        begin n_err++; $display("FAIL bp_hold j=%0d got v=%b lane=%b tag=%0d data=%0d busy=%b exp 1/0/5/6/1", j, resp_valid, resp_lane, resp_tag, resp_data, busy); end
      if (j < 3) step();
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    step();
    n_vec++; if (resp_valid !== 1'b1 || resp_lane !== 1'b1 || resp_tag !== 5'd6 || resp_data !== 32'd25)
      begin n_err++; $display("FAIL bp_second got v=%b lane=%b tag=%0d data=%0d exp 1/1/6/25", resp_valid, resp_lane, resp_tag, resp_data); end
    step();
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL bp_drain got v=%b busy=%b exp 0/0", resp_valid, busy); end
  endtask

  task automatic test_flush();
    resp_ready = 1'b0;
    set_lane(1, 32'd3, 32'd3, 5'd7, 2'b00);
    req_valid = 2'b10;
    step();
    set_lane(0, 32'd2, 32'd2, 5'd8, 2'b00);
    req_valid = 2'b01;
    step();
    n_vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd7)
      begin n_err++; $display("FAIL flush_pre got v=%b tag=%0d exp 1/7", resp_valid, resp_tag); end
    flush = 1'b1;
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL flush_ready got %b exp 00", req_ready); end
    step();
    flush = 1'b0;
    req_valid = 2'b00;
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL flush_clear got v=%b busy=%b exp 0/0", resp_valid, busy); end
    resp_ready = 1'b1;
    set_lane(1, 32'd6, 32'd7, 5'd10, 2'b00);
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL flush_rrptr got %b exp 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_vec++; if (resp_valid !== 1'b1 || resp_lane !== 1'b1 || resp_tag !== 5'd10 || resp_data !== 32'd42)
      begin n_err++; $display("FAIL flush_after got v=%b lane=%b tag=%0d data=%0d exp 1/1/10/42", resp_valid, resp_lane, resp_tag, resp_data); end
    step();
  endtask

  task automatic test_wrap();
    int          n;
    int          lane [5];
    logic [31:0] va   [5];
    logic [31:0] vb   [5];
    logic [4:0]  vt   [5];
    logic [1:0]  vo   [5];
    logic [31:0] vx   [5];
    lane[0] = 0; va[0] = 32'hFFFF_FFFF; vb[0] = 32'd2;          vt[0] = 5'd4;  vo[0] = 2'b00; vx[0] = 32'hFFFF_FFFE;
    lane[1] = 1; va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;  vt[1] = 5'd31; vo[1] = 2'b00; vx[1] = 32'h0000_0001;
    lane[2] = 0; va[2] = 32'hFFFF_FFFF; vb[2] = 32'd2;          vt[2] = 5'd4;  vo[2] = 2'b11; vx[2] = 32'h0000_0001;
    lane[3] = 1; va[3] = 32'hFFFF_FFFF; vb[3] = 32'd2;          vt[3] = 5'd4;  vo[3] = 2'b01; vx[3] = 32'hFFFF_FFFF;
    lane[4] = 0; va[4] = 32'hFFFF_FFFF; vb[4] = 32'd2;          vt[4] = 5'd4;  vo[4] = 2'b10; vx[4] = 32'hFFFF_FFFF;
`ifdef MUL_HIGH_EN
    n = 5;
`else
    n = 2;
`endif
    resp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_lane(lane[i], va[i], vb[i], vt[i], vo[i]);
      req_valid = (lane[i] == 1) ? 2'b10 : 2'b01;
      step();
      req_valid = 2'b00;
      step();
      n_vec++; if (resp_valid !== 1'b1 || resp_lane !== lane[i][0] || resp_tag !== vt[i] || resp_data !== vx[i])
        begin n_err++; $display("FAIL wrap_%0d got v=%b lane=%b tag=%0d data=%h exp 1/%0d/%0d/%h", i, resp_valid, resp_lane, resp_tag, resp_data, lane[i], vt[i], vx[i]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    resp_ready = 1'b1;
    set_lane(1, 32'd2, 32'd5, 5'd11, 2'b00);
    req_valid = 2'b10;
    step();
    set_lane(0, 32'd3, 32'd4, 5'd12, 2'b00);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    n_vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd11 || resp_data !== 32'd10)
      begin n_err++; $display("FAIL areset_pre got v=%b tag=%0d data=%0d exp 1/11/10", resp_valid, resp_tag, resp_data); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_lane !== 1'b0 || resp_tag !== 5'd0 || resp_data !== 32'd0 || req_ready !== 2'b00)
      begin n_err++; $display("FAIL areset_zero got v=%b busy=%b lane=%b tag=%0d data=%h ready=%b exp all 0", resp_valid, busy, resp_lane, resp_tag, resp_data, req_ready); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL areset_first_grant got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_vec++; if (resp_valid !== 1'b1 || resp_lane !== 1'b0 || resp_tag !== 5'd12 || resp_data !== 32'd12)
      begin n_err++; $display("FAIL areset_resp got v=%b lane=%b tag=%0d data=%0d exp 1/0/12/12", resp_valid, resp_lane, resp_tag, resp_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
